// File: rtl/coreuart_pkg.sv
// Shared helpers for the UART baud-rate generator: width derivation,
// parameter legality checks and the registered tick bundle.
package coreuart_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of the oversample counters (at least one bit).
  function automatic int ovs_width(input int ovs);
    return (clog2(ovs) < 1) ? 1 : clog2(ovs);
  endfunction

  // Stored width of the fractional divisor; a zero-width fraction keeps one dummy bit.
  function automatic int frac_store_width(input int frac_w);
    return (frac_w > 0) ? frac_w : 1;
  endfunction

  function automatic bit ovs_legal(input int ovs);
    return (ovs >= 2) && (ovs <= 256);
  endfunction

  function automatic bit rx_phase_legal(input int rx_phase, input int ovs);
    return (rx_phase >= 0) && (rx_phase < ovs);
  endfunction

  // Registered outputs of the generator.
  typedef struct packed {
    logic baud_tick;
    logic tx_tick;
    logic rx_sample;
  } tick_out_t;

endpackage

// File: rtl/coreuart_baud_gen_if.sv
// Divisor/control inputs and tick outputs of the baud generator.
// master = register file / TX / RX side, slave = the generator.
interface coreuart_baud_gen_if
  import coreuart_pkg::*;
#(
  parameter int CNT_W  = 13,
  parameter int FRAC_W = 3
);

  localparam int FW = frac_store_width(FRAC_W);

  logic             ENABLE;
  logic [CNT_W-1:0] BAUD_VAL;
  logic [FW-1:0]    BAUD_FRAC;
  logic             RX_RESYNC;
  logic             BAUD_TICK;
  logic             TX_TICK;
  logic             RX_SAMPLE;

  modport master (
    output ENABLE, BAUD_VAL, BAUD_FRAC, RX_RESYNC,
    input  BAUD_TICK, TX_TICK, RX_SAMPLE
  );

  modport slave (
    input  ENABLE, BAUD_VAL, BAUD_FRAC, RX_RESYNC,
    output BAUD_TICK, TX_TICK, RX_SAMPLE
  );

endinterface

// File: rtl/coreuart_frac_div.sv
// Integer-plus-fraction clock divider. A down-counter sets the base period
// of val+1 clocks; a fractional accumulator inserts one extra clock whenever
// it overflows, so the average period is val+1+frac/2^FRAC_W.
module coreuart_frac_div
  import coreuart_pkg::*;
#(
  parameter int CNT_W  = 13,
  parameter int FRAC_W = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [CNT_W-1:0]                    val,
  input  logic [frac_store_width(FRAC_W)-1:0] frac,
  output logic                                reload,
  output logic                                tick
);

  localparam int FW       = frac_store_width(FRAC_W);
  localparam bit HAS_FRAC = (FRAC_W > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    acc_q, acc_d;
  logic             stretch_q, stretch_d;
  logic [FW-1:0]    frac_in;
  logic [FW:0]      sum;

  // The divisor is consumed whenever the counter rests at zero (normal or stretch cycle).
  assign reload = (cnt_q == '0);

  // Next state: count down, or at zero either fire or hold one stretch cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can leave it unassigned and infer a latch.
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    stretch_d = stretch_q;
    tick      = 1'b0;
    frac_in   = HAS_FRAC ? frac : '0;
    sum       = {1'b0, acc_q} + {1'b0, frac_in};

    if (!enable) begin
      cnt_d     = '0;
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (stretch_q) begin
      tick      = 1'b1;
      cnt_d     = val;
      stretch_d = 1'b0;
    end else begin
      acc_d = sum[FW-1:0];
      if (sum[FW]) begin
        stretch_d = 1'b1;
      end else begin
        tick  = 1'b1;
        cnt_d = val;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end

endmodule

// File: rtl/coreuart_baud_gen.sv
// UART baud-rate generator: shadowed divisor, fractional divider, TX bit
// tick and a phase-realignable RX sample strobe. All outputs registered.
module coreuart_baud_gen
  import coreuart_pkg::*;
#(
  parameter int CNT_W    = 13,
  parameter int FRAC_W   = 3,
  parameter int OVS      = 16,
  parameter int RX_PHASE = OVS / 2 - 1
) (
  input logic                CLK,
  input logic                RESET_N,
  coreuart_baud_gen_if.slave bus
);

  localparam int               FW       = frac_store_width(FRAC_W);
  localparam int               OVS_W    = ovs_width(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] RX_HIT   = OVS_W'(RX_PHASE);

  if (!ovs_legal(OVS)) begin : g_bad_ovs
    $error("coreuart_baud_gen: OVS must be in 2..256");
  end
  if (!rx_phase_legal(RX_PHASE, OVS)) begin : g_bad_rx_phase
    $error("coreuart_baud_gen: RX_PHASE must be below OVS");
  end

  typedef struct packed {
    logic [CNT_W-1:0] val;
    logic [FW-1:0]    frac;
  } shadow_t;

  shadow_t          shadow_q, shadow_d;
  logic             load;
  logic             reload;
  logic             tick;
  logic [OVS_W-1:0] tx_ovs_q, tx_ovs_d;
  logic [OVS_W-1:0] rx_ovs_q, rx_ovs_d;
  tick_out_t        out_q, out_d;

  // Divisor is captured at every reload point and continuously while idle.
  assign load = !bus.ENABLE || reload;

  // Shadow next value; the divider reads it directly so a reload uses the value it captures.
  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
      shadow_d.val  = bus.BAUD_VAL;
      shadow_d.frac = bus.BAUD_FRAC;
    end
  end

  coreuart_frac_div #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .enable (bus.ENABLE),
    .val    (shadow_d.val),
    .frac   (shadow_d.frac),
    .reload (reload),
    .tick   (tick)
  );

  // Oversample counters and next output values; RX_RESYNC overrides a coincident tick for RX only.
  always_comb begin
    out_d    = '0;
    tx_ovs_d = tx_ovs_q;
    rx_ovs_d = rx_ovs_q;
    if (!bus.ENABLE) begin
      tx_ovs_d = '0;
      rx_ovs_d = '0;
    end else begin
      if (tick) begin
        out_d.baud_tick = 1'b1;
        if (tx_ovs_q == OVS_LAST) begin
          out_d.tx_tick = 1'b1;
          tx_ovs_d      = '0;
        end else begin
          tx_ovs_d = tx_ovs_q + OVS_W'(1);
        end
      end
      if (bus.RX_RESYNC) begin
        rx_ovs_d = '0;
      end else if (tick) begin
        out_d.rx_sample = (rx_ovs_q == RX_HIT);
        rx_ovs_d        = (rx_ovs_q == OVS_LAST) ? '0 : rx_ovs_q + OVS_W'(1);
      end
    end
  end

  // Shadow, counters and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the shadow is reset with the rest of the state so it never holds X; the load bypass lets the first reload after reset still see live inputs.
      shadow_q <= '0;
      tx_ovs_q <= '0;
      rx_ovs_q <= '0;
      out_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      tx_ovs_q <= tx_ovs_d;
      rx_ovs_q <= rx_ovs_d;
      out_q    <= out_d;
    end
  end

  assign bus.BAUD_TICK = out_q.baud_tick;
  assign bus.TX_TICK   = out_q.tx_tick;
  assign bus.RX_SAMPLE = out_q.rx_sample;

endmodule

// File: tb/tb_coreuart_baud_gen.sv
// Self-checking bench for coreuart_baud_gen (CNT_W=13, FRAC_W=3, OVS=16, RX_PHASE=7).
module tb_coreuart_baud_gen;

  localparam int CNT_W    = 13;
  localparam int FRAC_W   = 3;
  localparam int OVS      = 16;
  localparam int RX_PHASE = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  coreuart_baud_gen_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) bus ();

  coreuart_baud_gen #(
    .CNT_W    (CNT_W),
    .FRAC_W   (FRAC_W),
    .OVS      (OVS),
    .RX_PHASE (RX_PHASE)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int orphan  = 0;

  typedef struct {
    int val;
    int frac;
    int exp_first;   // cycles from ENABLE rise to first BAUD_TICK
    int exp_8;       // clocks spanned by 8 consecutive periods
    int exp_long;    // stretched periods among those 8
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.BAUD_TICK;
      1:       return bus.TX_TICK;
      default: return bus.RX_SAMPLE;
    endcase
  endfunction

  // Steps until the selected output is high; n = cycles taken, -1 on timeout.
  task automatic wait_sig(input int which, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      n++;
      if (sig(which)) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL timeout on output %0d after %0d cycles", which, limit);
    n = -1;
  endtask

  // Counts BAUD_TICKs until one carries RX_SAMPLE; -1 if none within 40 ticks.
  task automatic ticks_to_rx(output int t);
    int n;
    t = 0;
    for (int k = 0; k < 40; k++) begin
      wait_sig(0, 20, n);
      t++;
      if (bus.RX_SAMPLE) return;
    end
    t = -1;
  endtask

  task automatic restart(input int val, input int frac);
    bus.ENABLE    = 1'b0;
    bus.BAUD_VAL  = CNT_W'(val);
    bus.BAUD_FRAC = FRAC_W'(frac);
    step();
    step();
    bus.ENABLE = 1'b1;
  endtask

  // TX_TICK / RX_SAMPLE must never appear without BAUD_TICK.
  always @(negedge clk) begin
    if (rst_n && (bus.TX_TICK || bus.RX_SAMPLE) && !bus.BAUD_TICK) orphan++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   n, total, nlong, nbad, ticks, txat, t;

    vecs[0] = '{3, 0, 1, 32, 0};
    vecs[1] = '{3, 1, 1, 33, 1};
    vecs[2] = '{3, 4, 1, 36, 4};
    vecs[3] = '{0, 7, 1, 15, 7};
    vecs[4] = '{0, 0, 1,  8, 0};
    vecs[5] = '{9, 0, 1, 80, 0};
    vecs[6] = '{5, 3, 1, 51, 3};

    bus.ENABLE    = 1'b0;
    bus.BAUD_VAL  = '0;
    bus.BAUD_FRAC = '0;
    bus.RX_RESYNC = 1'b0;
    rst_n         = 1'b0;
    repeat (3) step();
    check("reset baud_tick", int'(bus.BAUD_TICK), 0);
    check("reset tx_tick", int'(bus.TX_TICK), 0);
    check("reset rx_sample", int'(bus.RX_SAMPLE), 0);
    rst_n = 1'b1;
    step();

    // Table: first-tick latency and period statistics over 8 ticks.
    for (int v = 0; v < 7; v++) begin
      restart(vecs[v].val, vecs[v].frac);
      wait_sig(0, 20, n);
      check($sformatf("v%0d first tick", v), n, vecs[v].exp_first);
      total = 0;
      nlong = 0;
      nbad  = 0;
      for (int p = 0; p < 8; p++) begin
        wait_sig(0, 40, n);
        total += n;
        if (n == vecs[v].val + 2) nlong++;
        else if (n != vecs[v].val + 1) nbad++;
      end
      check($sformatf("v%0d clocks per 8 ticks", v), total, vecs[v].exp_8);
      check($sformatf("v%0d stretched periods", v), nlong, vecs[v].exp_long);
      check($sformatf("v%0d illegal periods", v), nbad, 0);
    end

    // TX_TICK: 16th tick from enable (1 + 15*4 clocks), then every 64 clocks.
    restart(3, 0);
    wait_sig(1, 200, n);
    check("tx first", n, 61);
    check("tx with baud", int'(bus.BAUD_TICK), 1);
    wait_sig(1, 200, n);
    check("tx period", n, 64);

    // ENABLE dropped mid-count with tx_ovs=10, then raised.
    restart(3, 0);
    for (int k = 0; k < 10; k++) wait_sig(0, 20, n);
    step();
    step();
    bus.ENABLE = 1'b0;
    nbad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.BAUD_TICK || bus.TX_TICK || bus.RX_SAMPLE) nbad++;
    end
    check("outputs while disabled", nbad, 0);
    bus.ENABLE = 1'b1;
    wait_sig(0, 20, n);
    check("tick after enable rise", n, 1);
    ticks = 1;
    txat  = bus.TX_TICK ? 1 : 0;
    for (int k = 0; k < 30 && txat == 0; k++) begin
      wait_sig(0, 20, n);
      ticks++;
      if (bus.TX_TICK) txat = ticks;
    end
    check("tx tick index after re-enable", txat, 16);

    // BAUD_VAL 3 -> 9 one clock after a tick.
    wait_sig(0, 20, n);
    step();
    bus.BAUD_VAL = CNT_W'(9);
    wait_sig(0, 40, n);
    check("period during change", n + 1, 4);
    wait_sig(0, 40, n);
    check("first new period", n, 10);
    wait_sig(0, 40, n);
    check("second new period", n, 10);

    // RX_RESYNC off-tick, then coincident with the tick that would sample.
    restart(3, 0);
    wait_sig(0, 20, n);
    step();
    bus.RX_RESYNC = 1'b1;
    step();
    bus.RX_RESYNC = 1'b0;
    ticks_to_rx(t);
    check("rx after off-tick resync", t, 8);
    ticks_to_rx(t);
    check("rx period", t, 16);

    wait_sig(0, 20, n);
    step();
    bus.RX_RESYNC = 1'b1;
    step();
    bus.RX_RESYNC = 1'b0;
    nbad = 0;
    for (int k = 0; k < 7; k++) begin
      wait_sig(0, 20, n);
      if (bus.RX_SAMPLE) nbad++;
    end
    check("rx early samples", nbad, 0);
    step();
    step();
    step();
    bus.RX_RESYNC = 1'b1;
    step();
    bus.RX_RESYNC = 1'b0;
    check("coincident tick present", int'(bus.BAUD_TICK), 1);
    check("coincident sample suppressed", int'(bus.RX_SAMPLE), 0);
    ticks_to_rx(t);
    check("rx after coincident resync", t, 8);
    ticks_to_rx(t);
    check("rx period after coincident", t, 16);

    // Asynchronous reset during a tick, then restart from cnt=0.
    wait_sig(0, 20, n);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset baud_tick", int'(bus.BAUD_TICK), 0);
    check("async reset tx_tick", int'(bus.TX_TICK), 0);
    check("async reset rx_sample", int'(bus.RX_SAMPLE), 0);
    step();
    step();
    rst_n = 1'b1;
    wait_sig(0, 20, n);
    check("tick after reset release", n, 1);
    wait_sig(0, 20, n);
    check("period after reset", n, 4);
    wait_sig(1, 200, n);
    check("tx after reset", n, 56);

    check("tx/rx only with baud", orphan, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
